// File: rtl/camera_cfg_pkg.sv
// Shared types and constants for the camera configuration sequencer.
package camera_cfg_pkg;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_SEND,
    ST_DELAY,
    ST_DONE
  } state_t;

  localparam logic [15:0] CFG_END           = 16'hFFFF;
  localparam logic [7:0]  CFG_DELAY_OP      = 8'hF0;
  localparam logic [7:0]  CAMERA_ID_DEFAULT = 8'h42;

  // Width that holds the longest delay, 255 units of unit_cycles each.
  function automatic int delay_cnt_width(input int unit_cycles);
    return $clog2(255 * unit_cycles + 1);
  endfunction

endpackage

// File: rtl/camera_config_rom.sv
// Synchronous-read configuration table. Entry = {reg[15:8], val[7:0]};
// unlisted addresses return the end marker. TABLE_SEL 0 is the camera
// table; 1 and 2 are bring-up tables (zero-length delay, full 64 writes).
module camera_config_rom
  import camera_cfg_pkg::*;
#(
  parameter int ROM_AW    = 6,
  parameter int TABLE_SEL = 0
) (
  input  logic              clk,
  input  logic [ROM_AW-1:0] addr,
  output logic [15:0]       data
);

  function automatic logic [15:0] lookup(input int a);
    // NOTE: the result gets a default before the case, so every path is
    // assigned and no latch or stale value can be implied.
    lookup = CFG_END;
    case (TABLE_SEL)
      1: begin
        case (a)
          0:       lookup = 16'h1280;
          1:       lookup = 16'hF000;
          2:       lookup = 16'h40D0;
          default: lookup = CFG_END;
        endcase
      end
      2: lookup = {8'(a), ~8'(a)};
      default: begin
        case (a)
          0:       lookup = 16'h1280;  // COM7 soft reset
          1:       lookup = 16'hF00A;  // wait 10 ms for the sensor to settle
          2:       lookup = 16'h1204;  // RGB output
          3:       lookup = 16'h40D0;  // RGB565, full range
          4:       lookup = 16'h1101;  // clock prescale
          default: lookup = CFG_END;
        endcase
      end
    endcase
  endfunction

  // Registered read: data is valid the cycle after addr is presented.
  // NOTE: the read register has no reset; the sequencer only looks at it
  // in DECODE, one cycle after it has been loaded from a defined address.
  always_ff @(posedge clk) begin
    data <= lookup(int'(addr));
  end

endmodule

// File: rtl/camera_config_seq.sv
// Steps through the configuration table and hands each {register, value}
// pair to the I2C write engine with a send/taken handshake. Delay entries
// stall the walk; the sequence runs after reset and on each resend.
module camera_config_seq
  import camera_cfg_pkg::*;
#(
  parameter logic [7:0] CAMERA_ID         = CAMERA_ID_DEFAULT,
  parameter int         DELAY_UNIT_CYCLES = 50000,
  parameter int         ROM_AW            = 6,
  parameter int         TABLE_SEL         = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       resend,
  input  logic       taken,
  output logic       send,
  output logic [7:0] id,
  output logic [7:0] register,
  output logic [7:0] value,
  output logic       busy,
  output logic       done
);

  localparam int DELAY_CNT_W = delay_cnt_width(DELAY_UNIT_CYCLES);
  localparam logic [DELAY_CNT_W-1:0] UNIT_CYCLES = DELAY_CNT_W'(DELAY_UNIT_CYCLES);
  localparam logic [ROM_AW-1:0]      ADDR_LAST   = '1;

  state_t                  state;
  logic [ROM_AW-1:0]       addr;
  logic [15:0]             rom_data;
  logic [DELAY_CNT_W-1:0]  delay_cnt;
  logic                    at_last;

  camera_config_rom #(
    .ROM_AW   (ROM_AW),
    .TABLE_SEL(TABLE_SEL)
  ) u_rom (
    .clk (clk),
    .addr(addr),
    .data(rom_data)
  );

  assign id      = CAMERA_ID;
  // The last table slot finishes the sequence instead of wrapping to 0.
  assign at_last = (addr == ADDR_LAST);

  // Sequencer FSM with address counter, delay counter and registered outputs.
  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_FETCH;
      addr      <= '0;
      delay_cnt <= '0;
      send      <= 1'b0;
      register  <= 8'h00;
      value     <= 8'h00;
      busy      <= 1'b1;
      done      <= 1'b0;
    end else begin
      case (state)
        ST_FETCH: state <= ST_DECODE;

        ST_DECODE: begin
          if (rom_data == CFG_END) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (rom_data[15:8] == CFG_DELAY_OP) begin
            if (rom_data[7:0] != 8'h00) begin
              // Constant-coefficient product, reduced to shift-add at elaboration.
              delay_cnt <= DELAY_CNT_W'(rom_data[7:0]) * UNIT_CYCLES;
              state     <= ST_DELAY;
            end else if (at_last) begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              addr  <= addr + 1'b1;
              state <= ST_FETCH;
            end
          end else begin
            register <= rom_data[15:8];
            value    <= rom_data[7:0];
            send     <= 1'b1;
            state    <= ST_SEND;
          end
        end

        ST_SEND: begin
          if (taken) begin
            send <= 1'b0;
            if (at_last) begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              addr  <= addr + 1'b1;
              state <= ST_FETCH;
            end
          end
        end

        // Spends exactly n * DELAY_UNIT_CYCLES cycles here; the counter
        // reaches 0 on the exit edge.
        ST_DELAY: begin
          delay_cnt <= delay_cnt - 1'b1;
          if (delay_cnt == DELAY_CNT_W'(1)) begin
            if (at_last) begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              addr  <= addr + 1'b1;
              state <= ST_FETCH;
            end
          end
        end

        ST_DONE: begin
          if (resend) begin
            addr  <= '0;
            busy  <= 1'b1;
            done  <= 1'b0;
            state <= ST_FETCH;
          end
        end

        default: state <= ST_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_camera_config_seq.sv
// Bench for camera_config_seq: three instances (camera table, zero-delay
// table, 64-write table) each driven by a behavioural I2C engine model.
module tb_camera_config_seq;
  import camera_cfg_pkg::*;

  localparam int UNIT      = 4;
  localparam int N_INST    = 3;
  localparam int REC_DEPTH = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_i  [N_INST];
  logic       resend_i [N_INST];
  logic       send_o   [N_INST];
  logic [7:0] id_o     [N_INST];
  logic [7:0] reg_o    [N_INST];
  logic [7:0] val_o    [N_INST];
  logic       busy_o   [N_INST];
  logic       done_o   [N_INST];
  bit         hold = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] exp_w   [N_INST][128];
  int          exp_gap [N_INST][128];
  int          exp_n   [N_INST];

  // DUT instances plus engine model: takes a request 3 cycles after seeing
  // send, then stays busy 20 cycles. Records every accepted triple and the
  // number of send-low cycles until the next request.
  for (genvar gi = 0; gi < N_INST; gi++) begin : g_eng
    logic        taken;
    logic [23:0] rec [REC_DEPTH];
    int          gap [REC_DEPTH];
    int          rec_n    = 0;
    int          wait_cnt = 0;
    int          busy_cnt = 0;
    int          zero_cnt = 0;
    int          last_idx = -1;
    bit          counting = 1'b0;

    camera_config_seq #(
      .DELAY_UNIT_CYCLES(UNIT),
      .TABLE_SEL        (gi)
    ) u_dut (
      .clk     (clk),
      .reset   (reset_i[gi]),
      .resend  (resend_i[gi]),
      .taken   (taken),
      .send    (send_o[gi]),
      .id      (id_o[gi]),
      .register(reg_o[gi]),
      .value   (val_o[gi]),
      .busy    (busy_o[gi]),
      .done    (done_o[gi])
    );

    initial taken = 1'b0;

    always @(negedge clk) begin
      taken = 1'b0;
      if (counting) begin
        if (send_o[gi]) begin
          if (last_idx >= 0 && last_idx < REC_DEPTH) gap[last_idx] = zero_cnt;
          counting = 1'b0;
        end else begin
          zero_cnt++;
        end
      end
      if (busy_cnt > 0) begin
        busy_cnt--;
      end else if (wait_cnt > 0) begin
        if (!send_o[gi]) begin
          wait_cnt = 0;
        end else if (!(gi == 0 && hold)) begin
          wait_cnt--;
          if (wait_cnt == 0) begin
            taken = 1'b1;
            if (rec_n < REC_DEPTH) rec[rec_n] = {id_o[gi], reg_o[gi], val_o[gi]};
            last_idx = rec_n;
            rec_n++;
            busy_cnt = 20;
            counting = 1'b1;
            zero_cnt = 0;
          end
        end
      end else if (send_o[gi]) begin
        wait_cnt = 2;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] get_rec(input int inst, input int idx);
    if (idx < 0 || idx >= REC_DEPTH) return 24'h0;
    case (inst)
      0:       return g_eng[0].rec[idx];
      1:       return g_eng[1].rec[idx];
      default: return g_eng[2].rec[idx];
    endcase
  endfunction

  function automatic int get_rec_n(input int inst);
    case (inst)
      0:       return g_eng[0].rec_n;
      1:       return g_eng[1].rec_n;
      default: return g_eng[2].rec_n;
    endcase
  endfunction

  function automatic int get_gap(input int inst, input int idx);
    if (idx < 0 || idx >= REC_DEPTH) return -1;
    case (inst)
      0:       return g_eng[0].gap[idx];
      1:       return g_eng[1].gap[idx];
      default: return g_eng[2].gap[idx];
    endcase
  endfunction

  // Table contents as written in the specification / bring-up tables.
  function automatic logic [15:0] table_word(input int sel, input int idx);
    logic [7:0] a;
    a = 8'(idx);
    case (sel)
      0: case (idx)
           0: return 16'h1280; 1: return 16'hF00A; 2: return 16'h1204;
           3: return 16'h40D0; 4: return 16'h1101; default: return 16'hFFFF;
         endcase
      1: case (idx)
           0: return 16'h1280; 1: return 16'hF000; 2: return 16'h40D0;
           default: return 16'hFFFF;
         endcase
      default: return {a, ~a};
    endcase
  endfunction

  // Reference: list of writes and send-low gap after each write. A gap is
  // 2 cycles (fetch+decode) plus 2 + n*UNIT per intervening delay entry.
  task automatic build_model();
    for (int s = 0; s < N_INST; s++) begin
      int pend;
      exp_n[s] = 0;
      pend = 2;
      for (int idx = 0; idx < 64; idx++) begin
        logic [15:0] w;
        w = table_word(s, idx);
        if (w == 16'hFFFF) break;
        if (w[15:8] == 8'hF0) begin
          pend += 2 + int'(w[7:0]) * UNIT;
        end else begin
          if (exp_n[s] > 0) exp_gap[s][exp_n[s]-1] = pend;
          exp_w[s][exp_n[s]] = w;
          exp_n[s]++;
          pend = 2;
        end
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_done(input int inst, input int budget, input string tag);
    int c;
    c = 0;
    while (!done_o[inst] && c < budget) begin
      @(negedge clk);
      c++;
    end
    check(tag, done_o[inst], 1'b1);
  endtask

  task automatic pulse_resend(input int inst);
    resend_i[inst] = 1'b1;
    @(negedge clk);
    resend_i[inst] = 1'b0;
  endtask

  task automatic check_writes(input string tag, input int inst, input int base);
    check($sformatf("%s_count", tag), get_rec_n(inst) - base, exp_n[inst]);
    for (int j = 0; j < exp_n[inst]; j++)
      check($sformatf("%s_w%0d", tag, j), get_rec(inst, base + j), {8'h42, exp_w[inst][j]});
  endtask

  initial begin
    #(60000 * 10);
    $display("FAIL watchdog: got no completion, expected finish within 60000 cycles");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base, snap, lat, c, cnt;
    logic [7:0] r0, v0;
    bit changed;

    build_model();
    for (int i = 0; i < N_INST; i++) begin
      reset_i[i]  = 1'b1;
      resend_i[i] = 1'b0;
    end
    tick(3);

    check("rst_send", send_o[0], 1'b0);
    check("rst_register", reg_o[0], 8'h00);
    check("rst_value", val_o[0], 8'h00);
    check("rst_id", id_o[0], 8'h42);
    check("rst_busy", busy_o[0], 1'b1);
    check("rst_done", done_o[0], 1'b0);

    // Power-up sequence.
    for (int i = 0; i < N_INST; i++) reset_i[i] = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!send_o[0] && lat < 20);
    check("first_send_latency", lat, 2);
    wait_done(0, 2000, "seq0_done");
    check("seq0_busy", busy_o[0], 1'b0);
    check_writes("seq0", 0, 0);
    for (int j = 0; j + 1 < exp_n[0]; j++)
      check($sformatf("seq0_gap%0d", j), get_gap(0, j), exp_gap[0][j]);

    // Zero-length delay and full-table instances.
    wait_done(1, 2000, "f000_done");
    check_writes("f000", 1, 0);
    check("f000_gap0", get_gap(1, 0), exp_gap[1][0]);
    wait_done(2, 5000, "tbl64_done");
    check_writes("tbl64", 2, 0);
    tick(50);
    check("tbl64_no_wrap_count", get_rec_n(2), 64);
    check("tbl64_addr", g_eng[2].u_dut.addr, 6'h3F);
    check("tbl64_still_done", done_o[2], 1'b1);

    // Engine withholds taken for 1000 cycles; resend while busy is ignored.
    base = get_rec_n(0);
    hold = 1'b1;
    pulse_resend(0);
    check("resend_busy", busy_o[0], 1'b1);
    check("resend_done", done_o[0], 1'b0);
    c = 0;
    while (!send_o[0] && c < 20) begin
      @(negedge clk);
      c++;
    end
    check("hold_send_up", send_o[0], 1'b1);
    r0 = reg_o[0];
    v0 = val_o[0];
    check("hold_reg", r0, 8'h12);
    check("hold_val", v0, 8'h80);
    changed = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      resend_i[0] = (k == 500);
      @(negedge clk);
      if (send_o[0] !== 1'b1 || reg_o[0] !== r0 || val_o[0] !== v0) changed = 1'b1;
    end
    resend_i[0] = 1'b0;
    check("hold_stable", changed, 1'b0);
    check("hold_no_take", get_rec_n(0) - base, 0);
    hold = 1'b0;
    wait_done(0, 2000, "hold_done");
    check_writes("after_hold", 0, base);

    // Reset while counting a delay.
    base = get_rec_n(0);
    pulse_resend(0);
    c = 0;
    while (get_rec_n(0) == base && c < 100) begin
      @(negedge clk);
      c++;
    end
    check("first_take_seen", get_rec_n(0) - base, 1);
    tick(10);
    check("in_delay", g_eng[0].u_dut.state, ST_DELAY);
    reset_i[0] = 1'b1;
    @(negedge clk);
    check("mid_rst_send", send_o[0], 1'b0);
    check("mid_rst_addr", g_eng[0].u_dut.addr, 6'h00);
    check("mid_rst_busy", busy_o[0], 1'b1);
    reset_i[0] = 1'b0;
    snap = get_rec_n(0);
    wait_done(0, 2000, "mid_rst_done");
    check_writes("after_rst", 0, snap);

    // Randomized resend/reset traffic.
    for (int it = 0; it < 12; it++) begin
      base = get_rec_n(0);
      if ($urandom_range(0, 1) == 0) begin
        tick($urandom_range(0, 10));
        pulse_resend(0);
        c = 0;
        while (!done_o[0] && c < 2000) begin
          resend_i[0] = busy_o[0] && ($urandom_range(0, 7) == 0);
          @(negedge clk);
          c++;
        end
        resend_i[0] = 1'b0;
        check($sformatf("rnd%0d_done", it), done_o[0], 1'b1);
        check_writes($sformatf("rnd%0d", it), 0, base);
      end else begin
        pulse_resend(0);
        tick($urandom_range(1, 120));
        reset_i[0] = 1'b1;
        tick($urandom_range(1, 3));
        reset_i[0] = 1'b0;
        snap = get_rec_n(0);
        cnt = snap - base;
        check($sformatf("rnd%0d_prefix_len", it), cnt <= exp_n[0], 1'b1);
        for (int j = 0; j < cnt && j < exp_n[0]; j++)
          check($sformatf("rnd%0d_pre%0d", it, j), get_rec(0, base + j), {8'h42, exp_w[0][j]});
        wait_done(0, 2000, $sformatf("rnd%0d_rst_done", it));
        check_writes($sformatf("rnd%0d_rst", it), 0, snap);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
